// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the sequenced control unit:
// opcode/func encodings, FSM states and instruction classes.
package ctrl_seq_pkg;

   localparam logic [1:0] kRTYPE  = 2'b00;
   localparam logic [1:0] kLSTYPE = 2'b01;
   localparam logic [1:0] kSPTYPE = 2'b11;

   localparam logic [1:0] kEQ   = 2'b11;
   localparam logic [1:0] kLB   = 2'b00;
   localparam logic [1:0] kSB   = 2'b01;
   localparam logic [1:0] kHALT = 2'b11;

   typedef enum logic [1:0] {IDLE, RUN, MEM, HALT} ctrl_state_t;

   typedef enum {C_ALU, C_BR, C_LD, C_ST, C_HLT} instr_class_t;

   // Wait-counter width: enough for MEM_LAT-1, never below one bit.
   function automatic int cnt_w(input int lat);
      return (lat < 1) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: op/func fields
// at parametrised positions -> instruction class.
module ctrl_decode
   import ctrl_seq_pkg::*;
#(
   parameter int IW     = 9,
   parameter int OP_LSB = 6,
   parameter int FN_LSB = 4
) (
   input  logic [IW-1:0] instr_i,
   output instr_class_t  class_o
);

   logic [1:0] op;
   logic [1:0] fn;
   logic       unused_bits;

   assign op = instr_i[OP_LSB+1:OP_LSB];
   assign fn = instr_i[FN_LSB+1:FN_LSB];

   // Operand/immediate bits carry no control meaning here.
   assign unused_bits = ^instr_i;

   // Special op/func pairs map to their class; everything else is ALU.
   always_comb begin
      class_o = C_ALU;
      if (op == kRTYPE && fn == kEQ) begin
         class_o = C_BR;
      end else if (op == kLSTYPE && fn == kSB) begin
         class_o = C_ST;
      end else if (op == kLSTYPE && fn == kLB) begin
         class_o = C_LD;
      end else if (op == kSPTYPE && fn == kHALT) begin
         class_o = C_HLT;
      end
   end

endmodule

// File: rtl/ctrl_seq.sv
// Sequenced control unit: start/halt, valid gating and
// multi-cycle memory accesses that freeze the PC.
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int IW      = 9,
   parameter int OP_LSB  = 6,
   parameter int FN_LSB  = 4,
   parameter int MEM_LAT = 2
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic          InstrValid,
   input  logic [IW-1:0] Instruction,
   output logic          BranchEn,
   output logic          RegWriteEn,
   output logic          MemWriteEn,
   output logic          MemReadEn,
   output logic          PcEn,
   output logic          Stall,
   output logic          Halted
);

   localparam int CW = cnt_w(MEM_LAT);
   localparam logic [CW-1:0] CNT_INIT =
      CW'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

   ctrl_state_t  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   instr_class_t cls_q, cls_d;
   instr_class_t cls;

   ctrl_decode #(
      .IW     (IW),
      .OP_LSB (OP_LSB),
      .FN_LSB (FN_LSB)
   ) u_decode (
      .instr_i (Instruction),
      .class_o (cls)
   );

   // State, wait counter and held memory-op class.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cls_q   <= C_ALU;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cls_q   <= cls_d;
      end
   end

   // Next state and Mealy outputs; all outputs default low.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cls_d      = cls_q;
      BranchEn   = 1'b0;
      RegWriteEn = 1'b0;
      MemWriteEn = 1'b0;
      MemReadEn  = 1'b0;
      PcEn       = 1'b0;
      Stall      = 1'b0;
      Halted     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (Start) state_d = RUN;
         end
         RUN: begin
            if (InstrValid) begin
               unique case (cls)
                  C_ALU: begin
                     RegWriteEn = 1'b1;
                     PcEn       = 1'b1;
                  end
                  C_BR: begin
                     BranchEn = 1'b1;
                     PcEn     = 1'b1;
                  end
                  C_LD, C_ST: begin
                     MemReadEn  = (cls == C_LD);
                     MemWriteEn = (cls == C_ST);
                     if (MEM_LAT == 0) begin
                        PcEn       = 1'b1;
                        RegWriteEn = (cls == C_LD);
                     end else begin
                        // Strobe once, then wait out the latency in MEM.
                        Stall   = 1'b1;
                        cnt_d   = CNT_INIT;
                        cls_d   = cls;
                        state_d = MEM;
                     end
                  end
                  C_HLT: begin
                     state_d = HALT;
                  end
                  default: ;
               endcase
            end
         end
         MEM: begin
            if (cnt_q != '0) begin
               Stall = 1'b1;
               cnt_d = cnt_q - 1'b1;
            end else begin
               PcEn       = 1'b1;
               RegWriteEn = (cls_q == C_LD);
               state_d    = RUN;
            end
         end
         HALT: begin
            Halted = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: two instances (MEM_LAT 0 and 2)
// against an expected-output-sequence model.
module tb_ctrl_seq;
   import ctrl_seq_pkg::*;

   localparam logic [6:0] V_BR = 7'b0000001;
   localparam logic [6:0] V_RW = 7'b0000010;
   localparam logic [6:0] V_MW = 7'b0000100;
   localparam logic [6:0] V_MR = 7'b0001000;
   localparam logic [6:0] V_PC = 7'b0010000;
   localparam logic [6:0] V_ST = 7'b0100000;
   localparam logic [6:0] V_HL = 7'b1000000;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Start;
   logic       InstrValid;
   logic [8:0] Instruction;
   logic [1:0] br, rw, mw, mr, pc, st, hl;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit done   = 1'b0;

   int started [2];
   int halted  [2];
   logic [6:0] q0 [$];
   logic [6:0] q2 [$];

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   ctrl_seq #(.MEM_LAT(0)) u0 (
      .Clk(Clk), .Reset(Reset), .Start(Start),
      .InstrValid(InstrValid), .Instruction(Instruction),
      .BranchEn(br[0]), .RegWriteEn(rw[0]),
      .MemWriteEn(mw[0]), .MemReadEn(mr[0]),
      .PcEn(pc[0]), .Stall(st[0]), .Halted(hl[0])
   );

   ctrl_seq #(.MEM_LAT(2)) u2 (
      .Clk(Clk), .Reset(Reset), .Start(Start),
      .InstrValid(InstrValid), .Instruction(Instruction),
      .BranchEn(br[1]), .RegWriteEn(rw[1]),
      .MemWriteEn(mw[1]), .MemReadEn(mr[1]),
      .PcEn(pc[1]), .Stall(st[1]), .Halted(hl[1])
   );

   function automatic logic [6:0] outv(input int k);
      return {hl[k], st[k], pc[k], mr[k], mw[k], rw[k], br[k]};
   endfunction

   function automatic int lat_of(input int k);
      return (k == 1) ? 2 : 0;
   endfunction

   function automatic logic [8:0] mk(input logic [1:0] op,
                                     input logic [1:0] fn);
      return {1'b0, op, fn, 4'h5};
   endfunction

   // 0 ALU, 1 BR, 2 LD, 3 ST, 4 HLT
   function automatic int bclass(input logic [8:0] i);
      if (i[7:6] == kRTYPE  && i[5:4] == kEQ)   return 1;
      if (i[7:6] == kLSTYPE && i[5:4] == kLB)   return 2;
      if (i[7:6] == kLSTYPE && i[5:4] == kSB)   return 3;
      if (i[7:6] == kSPTYPE && i[5:4] == kHALT) return 4;
      return 0;
   endfunction

   task automatic qpush(input int k, input logic [6:0] v);
      if (k == 0) q0.push_back(v);
      else        q2.push_back(v);
   endtask

   task automatic check(input string name, input logic [6:0] got,
                        input logic [6:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   // Model: each accepted instruction emits its whole output sequence.
   task automatic step(input int k, output logic [6:0] e);
      int L;
      int c;
      logic [6:0] strobe, fin;
      L = lat_of(k);
      e = '0;
      if (!Reset) begin
         if (k == 0) q0.delete();
         else        q2.delete();
         started[k] = 0;
         halted[k]  = 0;
      end else if (halted[k] != 0) begin
         e = V_HL;
      end else if (started[k] == 0) begin
         if (Start) started[k] = 1;
      end else if (k == 0 && q0.size() > 0) begin
         e = q0.pop_front();
      end else if (k == 1 && q2.size() > 0) begin
         e = q2.pop_front();
      end else if (InstrValid) begin
         c = bclass(Instruction);
         case (c)
            0: e = V_RW | V_PC;
            1: e = V_BR | V_PC;
            2, 3: begin
               strobe = (c == 2) ? V_MR : V_MW;
               fin    = V_PC | ((c == 2) ? V_RW : 7'b0);
               if (L == 0) begin
                  e = strobe | fin;
               end else begin
                  e = strobe | V_ST;
                  for (int j = 0; j < L - 1; j++) qpush(k, V_ST);
                  qpush(k, fin);
               end
            end
            default: halted[k] = 1;
         endcase
      end
   endtask

   // Every cycle, both instances against the model.
   always @(negedge Clk) begin
      logic [6:0] e;
      if (!done) begin
         for (int k = 0; k < 2; k++) begin
            step(k, e);
            check($sformatf("model cyc%0d dut%0d", cyc, k),
                  outv(k), e);
         end
      end
   end

   task automatic drive(input logic r, input logic s,
                        input logic v, input logic [8:0] ins);
      @(posedge Clk);
      #1;
      Reset       = r;
      Start       = s;
      InstrValid  = v;
      Instruction = ins;
      @(negedge Clk);
      #1;
   endtask

   logic [8:0] ALU, BR, LD, ST, HLT;

   initial begin
      ALU = mk(kRTYPE, 2'b00);
      BR  = mk(kRTYPE, kEQ);
      LD  = mk(kLSTYPE, kLB);
      ST  = mk(kLSTYPE, kSB);
      HLT = mk(kSPTYPE, kHALT);
      Reset = 1'b0; Start = 1'b1;
      InstrValid = 1'b1; Instruction = ALU;

      drive(0, 1, 1, ALU);
      drive(0, 1, 1, ALU);
      check("rst lat0", outv(0), 7'b0);
      check("rst lat2", outv(1), 7'b0);
      drive(1, 0, 1, ALU);
      check("idle", outv(1), 7'b0);
      drive(1, 1, 0, ALU);
      check("start", outv(1), 7'b0);
      drive(1, 0, 1, ALU);
      check("alu lat2", outv(1), 7'b0010010);
      check("alu lat0", outv(0), 7'b0010010);
      drive(1, 0, 0, ALU);
      check("novalid", outv(1), 7'b0);
      drive(1, 0, 1, LD);
      check("ld c0 lat2", outv(1), 7'b0101000);
      check("ld lat0", outv(0), 7'b0011010);
      drive(1, 0, 1, ALU);
      check("ld c1 lat2", outv(1), 7'b0100000);
      drive(1, 0, 1, ALU);
      check("ld c2 lat2", outv(1), 7'b0010010);
      drive(1, 0, 1, ST);
      check("st lat0", outv(0), 7'b0010100);
      check("st c0 lat2", outv(1), 7'b0100100);
      drive(1, 0, 0, ALU);
      drive(1, 0, 0, ALU);
      check("st c2 lat2", outv(1), 7'b0010000);
      drive(1, 0, 1, BR);
      check("br lat0", outv(0), 7'b0010001);
      check("br lat2", outv(1), 7'b0010001);

      for (int i = 0; i < 16; i++) begin
         logic [3:0] f;
         f = 4'(i);
         if (!(f[3:2] == kSPTYPE && f[1:0] == kHALT))
            drive(1, 0, 1, mk(f[3:2], f[1:0]));
      end
      for (int i = 0; i < 3; i++) drive(1, 0, 0, ALU);

      drive(1, 0, 1, LD);
      drive(0, 0, 1, ALU);
      check("rst mem", outv(1), 7'b0);
      drive(1, 0, 1, ALU);
      check("post rst", outv(1), 7'b0);
      drive(1, 0, 1, ALU);
      check("post rst idle", outv(1), 7'b0);

      drive(1, 1, 0, ALU);
      drive(1, 0, 1, HLT);
      check("hlt issue", outv(1), 7'b0);
      drive(1, 1, 1, ALU);
      check("halted lat0", outv(0), 7'b1000000);
      check("halted lat2", outv(1), 7'b1000000);
      drive(1, 0, 1, LD);
      drive(1, 1, 0, ALU);
      check("halt sticky", outv(1), 7'b1000000);
      drive(0, 0, 0, ALU);
      check("rst halt", outv(1), 7'b0);

      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
